// File: rtl/rare_node_activity_monitor_if.sv
// Readout stream of the rare-node activity monitor.
// Master drives beats (idx, count); slave returns ready.
interface rare_node_activity_monitor_if #(
  parameter int IW    = 4,
  parameter int CNT_W = 16
);
  logic             rd_valid;
  logic             rd_ready;
  logic [IW-1:0]    rd_idx;
  logic [CNT_W-1:0] rd_cnt;

  modport master (
    output rd_valid,
    output rd_idx,
    output rd_cnt,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_idx,
    input  rd_cnt,
    output rd_ready
  );
endinterface

// File: rtl/rare_node_activity_monitor.sv
// Per-node rare-value activation counter with N-detect mask and streamed readout.
// Optional STUCK_DETECT_EN adds stuck_mask (nodes that never toggled in the window).
module rare_node_activity_monitor #(
  parameter int NUM_NODES = 8,
  parameter int CNT_W     = 16,
  parameter int WIN_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIN_W-1:0]     win_len,
  input  logic [CNT_W-1:0]     thresh,
  input  logic [NUM_NODES-1:0] rare_pol,
  input  logic                 pat_valid,
  input  logic [NUM_NODES-1:0] node_i,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_NODES-1:0] cov_mask,
`ifdef STUCK_DETECT_EN
  output logic [NUM_NODES-1:0] stuck_mask,
`endif
  rare_node_activity_monitor_if.master rd
);
  localparam int IW = $clog2(NUM_NODES) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] READ = 2'd2;

  logic [1:0]           state;
  logic [WIN_W-1:0]     pat_cnt;
  logic [WIN_W-1:0]     win_q;
  logic [CNT_W-1:0]     thr_q;
  logic [NUM_NODES-1:0] pol_q;
  logic [IW-1:0]        idx_q;
  logic [CNT_W-1:0]     cnt    [NUM_NODES];
  logic [CNT_W-1:0]     cnt_nx [NUM_NODES];
  logic [NUM_NODES-1:0] cov_nx;
  logic [CNT_W-1:0]     cnt_sel;
  logic                 go;
  logic                 accept;
  logic                 last;
  logic                 beat;
  logic                 last_beat;

  assign go        = !abort && state == IDLE && start;
  assign accept    = !abort && state == RUN && pat_valid;
  assign last      = (pat_cnt + WIN_W'(1)) == win_q;
  assign beat      = state == READ && rd.rd_ready;
  assign last_beat = beat && idx_q == IW'(NUM_NODES - 1);

  assign busy        = state != IDLE;
  assign rd.rd_valid = state == READ;
  assign rd.rd_idx   = idx_q;
  assign rd.rd_cnt   = cnt_sel;

  // Counts after the current pattern, saturating, and the mask they imply.
  always_comb begin
    cov_nx = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      cnt_nx[i] = cnt[i];
      if (node_i[i] == pol_q[i] && cnt[i] != '1)
        cnt_nx[i] = cnt[i] + CNT_W'(1);
      cov_nx[i] = cnt_nx[i] >= thr_q;
    end
  end

  // Readout mux: count of the node addressed by the current beat.
  always_comb begin
    cnt_sel = '0;
    for (int i = 0; i < NUM_NODES; i++)
      if (idx_q == IW'(i))
        cnt_sel = cnt[i];
  end

  // Window control, counters and readout sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      done     <= 1'b0;
      cov_mask <= '0;
      idx_q    <= '0;
      pat_cnt  <= '0;
      win_q    <= '0;
      thr_q    <= '0;
      pol_q    <= '0;
      for (int i = 0; i < NUM_NODES; i++)
        cnt[i] <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state    <= IDLE;
        cov_mask <= '0;
        idx_q    <= '0;
      end else begin
        case (state)
          IDLE: if (start) begin
            pat_cnt <= '0;
            win_q   <= win_len;
            thr_q   <= thresh;
            pol_q   <= rare_pol;
            idx_q   <= '0;
            for (int i = 0; i < NUM_NODES; i++)
              cnt[i] <= '0;
            if (win_len == '0) begin
              state    <= READ;
              cov_mask <= {NUM_NODES{thresh == '0}};
            end else begin
              state    <= RUN;
              cov_mask <= '0;
            end
          end
          RUN: if (pat_valid) begin
            pat_cnt <= pat_cnt + WIN_W'(1);
            for (int i = 0; i < NUM_NODES; i++)
              cnt[i] <= cnt_nx[i];
            if (last) begin
              state    <= READ;
              cov_mask <= cov_nx;
            end
          end
          READ: if (beat) begin
            if (last_beat) begin
              state <= IDLE;
              idx_q <= '0;
              done  <= 1'b1;
            end else begin
              idx_q <= idx_q + IW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef STUCK_DETECT_EN
  logic [NUM_NODES-1:0] prev_q;
  logic [NUM_NODES-1:0] tog_q;
  logic [NUM_NODES-1:0] tog_nx;

  assign tog_nx = tog_q |
    ((pat_cnt != '0) ? (node_i ^ prev_q) : '0);

  // Toggle tracking; the first pattern of a window only seeds prev_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q     <= '0;
      tog_q      <= '0;
      stuck_mask <= '0;
    end else if (abort) begin
      stuck_mask <= '0;
    end else if (go) begin
      tog_q      <= '0;
      stuck_mask <= (win_len == '0) ? '1 : '0;
    end else if (accept) begin
      prev_q <= node_i;
      tog_q  <= tog_nx;
      if (last)
        stuck_mask <= ~tog_nx;
    end
  end
`else
  logic unused_go;
  assign unused_go = go ^ accept;
`endif
endmodule

// File: tb/tb_rare_node_activity_monitor.sv
// Directed bench for rare_node_activity_monitor.
// Runs a 16-bit-counter and a 2-bit-counter instance in lockstep.
module tb_rare_node_activity_monitor;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] win_len = '0;
  logic [15:0] thresh = '0;
  logic [1:0]  thresh_s = '0;
  logic [7:0]  rare_pol = '0;
  logic        pat_valid = 1'b0;
  logic [7:0]  node_i = '0;
  logic        rd_ready = 1'b0;
  logic        busy, done, busy_s, done_s;
  logic [7:0]  cov_mask, cov_s;
`ifdef STUCK_DETECT_EN
  logic [7:0]  stuck_mask, stuck_s;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int exp_cnt [8];

  rare_node_activity_monitor_if #(.IW(4), .CNT_W(16)) rda ();
  rare_node_activity_monitor_if #(.IW(4), .CNT_W(2))  rdb ();
  assign rda.rd_ready = rd_ready;
  assign rdb.rd_ready = rd_ready;

  always #5 clk = ~clk;

  rare_node_activity_monitor #(
    .NUM_NODES(8), .CNT_W(16), .WIN_W(16)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .win_len(win_len), .thresh(thresh), .rare_pol(rare_pol),
    .pat_valid(pat_valid), .node_i(node_i),
    .busy(busy), .done(done), .cov_mask(cov_mask),
`ifdef STUCK_DETECT_EN
    .stuck_mask(stuck_mask),
`endif
    .rd(rda)
  );

  rare_node_activity_monitor #(
    .NUM_NODES(8), .CNT_W(2), .WIN_W(16)
  ) u_sat (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .win_len(win_len), .thresh(thresh_s), .rare_pol(rare_pol),
    .pat_valid(pat_valid), .node_i(node_i),
    .busy(busy_s), .done(done_s), .cov_mask(cov_s),
`ifdef STUCK_DETECT_EN
    .stuck_mask(stuck_s),
`endif
    .rd(rdb)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic go(input int wl, input int th, input int ths,
                    input logic [7:0] pol);
    win_len  = 16'(wl);
    thresh   = 16'(th);
    thresh_s = 2'(ths);
    rare_pol = pol;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic pat(input logic [7:0] v);
    pat_valid = 1'b1;
    node_i    = v;
    tick();
    pat_valid = 1'b0;
  endtask

  task automatic do_abort();
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic read_all(input int stall_beat, input int stall_n);
    int es;
    for (int b = 0; b < 8; b++) begin
      es = (exp_cnt[b] > 3) ? 3 : exp_cnt[b];
      if (b == stall_beat) begin
        rd_ready = 1'b0;
        for (int k = 0; k < stall_n; k++) begin
          tick();
          chk("stall_idx", 32'(rda.rd_idx), 32'(b));
          chk("stall_cnt", 32'(rda.rd_cnt), 32'(exp_cnt[b]));
        end
      end
      rd_ready = 1'b1;
      chk("rd_valid", 32'(rda.rd_valid), 1);
      chk("rd_idx", 32'(rda.rd_idx), 32'(b));
      chk("rd_cnt", 32'(rda.rd_cnt), 32'(exp_cnt[b]));
      chk("rd_cnt_sat", 32'(rdb.rd_cnt), 32'(es));
      chk("done_early", 32'(done), 0);
      tick();
    end
    rd_ready = 1'b0;
    chk("done_pulse", 32'(done), 1);
    chk("done_pulse_s", 32'(done_s), 1);
    chk("rd_valid_end", 32'(rda.rd_valid), 0);
    chk("busy_end", 32'(busy), 0);
    tick();
    chk("done_once", 32'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cov", 32'(cov_mask), 0);
    chk("rst_valid", 32'(rda.rd_valid), 0);
    chk("rst_idx", 32'(rda.rd_idx), 0);
    chk("rst_cnt", 32'(rda.rd_cnt), 0);

    // 1: basic window with an idle gap
    go(4, 2, 2, 8'h00);
    chk("t1_busy", 32'(busy), 1);
    pat(8'h0F);
    pat(8'h0F);
    pat(8'h0F);
    tick();
    chk("t1_gap", 32'(rda.rd_valid), 0);
    pat(8'h0F);
    chk("t1_cov", 32'(cov_mask), 32'hF0);
    chk("t1_cov_s", 32'(cov_s), 32'hF0);
    for (int i = 0; i < 8; i++) exp_cnt[i] = (i < 4) ? 0 : 4;
    read_all(-1, 0);
    chk("t1_cov_hold", 32'(cov_mask), 32'hF0);

    // 2: saturation of the 2-bit instance
    go(10, 3, 3, 8'h00);
    for (int i = 0; i < 9; i++) pat(8'hFE);
    chk("t2_not_yet", 32'(rda.rd_valid), 0);
    pat(8'hFE);
    chk("t2_cov", 32'(cov_mask), 32'h01);
    chk("t2_cov_s", 32'(cov_s), 32'h01);
    for (int i = 0; i < 8; i++) exp_cnt[i] = (i == 0) ? 10 : 0;
    read_all(-1, 0);

    // 3: backpressure on beat 2
    go(2, 1, 1, 8'hFF);
    pat(8'hFF);
    pat(8'h0F);
    chk("t3_cov", 32'(cov_mask), 32'hFF);
    for (int i = 0; i < 8; i++) exp_cnt[i] = (i < 4) ? 2 : 1;
    read_all(2, 5);

    // 4: abort mid-window, then a fresh window
    go(6, 1, 1, 8'h00);
    pat(8'h00);
    pat(8'h00);
    do_abort();
    chk("t4_busy", 32'(busy), 0);
    chk("t4_valid", 32'(rda.rd_valid), 0);
    chk("t4_cov", 32'(cov_mask), 0);
    tick();
    tick();
    chk("t4_no_done", 32'(done), 0);
    go(1, 1, 1, 8'h00);
    pat(8'hAA);
    chk("t4_cov2", 32'(cov_mask), 32'h55);
    for (int i = 0; i < 8; i++) exp_cnt[i] = (i % 2 == 0) ? 1 : 0;
    read_all(-1, 0);

    // 5: empty window, start and patterns during READ ignored
    go(0, 0, 0, 8'h00);
    chk("t5_valid", 32'(rda.rd_valid), 1);
    chk("t5_cov", 32'(cov_mask), 32'hFF);
    go(5, 1, 1, 8'h00);
    pat(8'h00);
    chk("t5_idx", 32'(rda.rd_idx), 0);
    chk("t5_cov_kept", 32'(cov_mask), 32'hFF);
    for (int i = 0; i < 8; i++) exp_cnt[i] = 0;
    read_all(-1, 0);
    go(0, 1, 1, 8'h00);
    chk("t5_cov_th1", 32'(cov_mask), 0);
    do_abort();

`ifdef STUCK_DETECT_EN
    // 6: toggle tracking
    go(3, 1, 1, 8'h00);
    pat(8'h00);
    tick();
    pat(8'h02);
    pat(8'h00);
    chk("t6_stuck", 32'(stuck_mask), 32'hFD);
    chk("t6_stuck_s", 32'(stuck_s), 32'hFD);
    do_abort();
    chk("t6_stuck_clr", 32'(stuck_mask), 0);
`endif

    // rst in READ and mid-RUN
    go(1, 0, 0, 8'h00);
    pat(8'h00);
    chk("rst_pre_cov", 32'(cov_mask), 32'hFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_cov", 32'(cov_mask), 0);
    chk("rst2_valid", 32'(rda.rd_valid), 0);
    go(5, 1, 1, 8'h00);
    pat(8'h00);
    pat(8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst3_busy", 32'(busy), 0);
    chk("rst3_cnt", 32'(rda.rd_cnt), 0);
    chk("rst3_done", 32'(done), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
